// File: rtl/bpu_upd_sched.sv
// Branch predictor update scheduler: in-order queue from two execute pipes onto one predictor write port.
// Optional same-cycle bypass of req0 into an empty queue is enabled by defining BPU_UPD_BYPASS_EN.
module bpu_upd_sched #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req0_valid,
   input  logic [31:0]      req0_pc,
   input  logic [31:0]      req0_dest,
   input  logic [31:0]      req0_ret,
   input  logic [4:0]       req0_kind,
   input  logic             req0_taken,
   input  logic             req1_valid,
   input  logic [31:0]      req1_pc,
   input  logic [31:0]      req1_dest,
   input  logic [31:0]      req1_ret,
   input  logic [4:0]       req1_kind,
   input  logic             req1_taken,
   input  logic             flush_in,
   output logic             upd_valid,
   output logic [31:0]      upd_pc,
   output logic [31:0]      upd_dest,
   output logic [31:0]      upd_ret,
   output logic             upd_is_branch,
   output logic             upd_is_j,
   output logic             upd_is_jal,
   output logic             upd_is_jalr,
   output logic             upd_is_jr_ra,
   output logic             upd_taken,
   output logic             flush_ras,
   output logic             stall,
   output logic [CNT_W-1:0] drop_cnt
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] STALL_TH = (AW+1)'(DEPTH - 2);

   typedef enum logic {RUN, FLUSH} state_t;

   state_t           state_q, state_d;
   logic [AW-1:0]    head_q, tail_q;
   logic [AW:0]      count_q;
   logic [CNT_W-1:0] drop_q;

   logic [31:0]      pc_mem   [DEPTH];
   logic [31:0]      dest_mem [DEPTH];
   logic [31:0]      ret_mem  [DEPTH];
   logic [4:0]       kind_mem [DEPTH];
   logic             taken_mem[DEPTH];

   logic             v0, v1, deq, byp, acc0, acc1;
   logic [1:0]       n_enq, n_drop;
   logic [AW+1:0]    free_slots;
   logic [AW-1:0]    wr1_idx;
   logic [4:0]       sel_kind;

   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [1:0] b);
      logic [CNT_W:0] sum;
      sum = {1'b0, a} + {{(CNT_W-1){1'b0}}, b};
      return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
   endfunction

   always_comb begin
      state_d   = state_q;
      flush_ras = (state_q == FLUSH);
      v0        = req0_valid && (req0_kind != 5'd0);
      v1        = req1_valid && (req1_kind != 5'd0);
      case (state_q)
         RUN:     if (flush_in) state_d = FLUSH;
         FLUSH:   state_d = flush_in ? FLUSH : RUN;
         default: state_d = RUN;
      endcase
      // the predictor always accepts, so presenting the head is dequeuing it
      deq = (state_q == RUN) && !flush_in && (count_q != '0);
`ifdef BPU_UPD_BYPASS_EN
      byp = (state_q == RUN) && !flush_in && (count_q == '0) && v0;
`else
      byp = 1'b0;
`endif
      free_slots = (AW+2)'(DEPTH) - (AW+2)'(count_q) + (AW+2)'(deq);
      acc0       = !flush_in && v0 && !byp && (free_slots >= (AW+2)'(1));
      acc1       = !flush_in && v1 && (free_slots >= (acc0 ? (AW+2)'(2) : (AW+2)'(1)));
      n_enq      = {1'b0, acc0} + {1'b0, acc1};
      n_drop     = flush_in ? 2'd0
                 : ({1'b0, v0 && !byp && !acc0} + {1'b0, v1 && !acc1});
      wr1_idx    = acc0 ? tail_q + AW'(1) : tail_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= RUN;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         drop_q  <= '0;
      end else begin
         state_q <= state_d;
         drop_q  <= sat_add(drop_q, n_drop);
         if (flush_in) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
         end else begin
            head_q  <= head_q + AW'(deq);
            tail_q  <= tail_q + AW'(n_enq);
            count_q <= count_q + (AW+1)'(n_enq) - (AW+1)'(deq);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (acc0) begin
         pc_mem[tail_q]    <= req0_pc;
         dest_mem[tail_q]  <= req0_dest;
         ret_mem[tail_q]   <= req0_ret;
         kind_mem[tail_q]  <= req0_kind;
         taken_mem[tail_q] <= req0_taken;
      end
      if (acc1) begin
         pc_mem[wr1_idx]    <= req1_pc;
         dest_mem[wr1_idx]  <= req1_dest;
         ret_mem[wr1_idx]   <= req1_ret;
         kind_mem[wr1_idx]  <= req1_kind;
         taken_mem[wr1_idx] <= req1_taken;
      end
   end

   // output stage: fields are forced to zero whenever no update is presented
   always_comb begin
      upd_valid = deq || byp;
      upd_pc    = '0;
      upd_dest  = '0;
      upd_ret   = '0;
      upd_taken = 1'b0;
      sel_kind  = '0;
      if (byp) begin
         upd_pc    = req0_pc;
         upd_dest  = req0_dest;
         upd_ret   = req0_ret;
         upd_taken = req0_taken;
         sel_kind  = req0_kind;
      end else if (deq) begin
         upd_pc    = pc_mem[head_q];
         upd_dest  = dest_mem[head_q];
         upd_ret   = ret_mem[head_q];
         upd_taken = taken_mem[head_q];
         sel_kind  = kind_mem[head_q];
      end
   end

   assign upd_is_branch = sel_kind[0];
   assign upd_is_j      = sel_kind[1];
   assign upd_is_jal    = sel_kind[2];
   assign upd_is_jalr   = sel_kind[3];
   assign upd_is_jr_ra  = sel_kind[4];
   assign stall         = count_q > STALL_TH;
   assign drop_cnt      = drop_q;

endmodule

// File: tb/tb_bpu_upd_sched.sv
// Directed and random stimulus for bpu_upd_sched with a queue-based expected-update scoreboard.
module tb_bpu_upd_sched;
   localparam int DEPTH = 4;
   localparam int CNT_W = 8;
   localparam int SAT   = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             reset;
   logic             req0_valid, req1_valid, req0_taken, req1_taken, flush_in;
   logic [31:0]      req0_pc, req0_dest, req0_ret, req1_pc, req1_dest, req1_ret;
   logic [4:0]       req0_kind, req1_kind;
   logic             upd_valid, upd_is_branch, upd_is_j, upd_is_jal, upd_is_jalr, upd_is_jr_ra;
   logic             upd_taken, flush_ras, stall;
   logic [31:0]      upd_pc, upd_dest, upd_ret;
   logic [CNT_W-1:0] drop_cnt;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] dest;
      logic [31:0] ret;
      logic [4:0]  kind;
      logic        taken;
   } upd_t;

   upd_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   m_drop = 0;
   bit   m_flush = 1'b0;
   int   seq = 0;

   always #5 clk = ~clk;

   bpu_upd_sched #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_pc(req0_pc), .req0_dest(req0_dest), .req0_ret(req0_ret),
      .req0_kind(req0_kind), .req0_taken(req0_taken),
      .req1_valid(req1_valid), .req1_pc(req1_pc), .req1_dest(req1_dest), .req1_ret(req1_ret),
      .req1_kind(req1_kind), .req1_taken(req1_taken),
      .flush_in(flush_in),
      .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_dest(upd_dest), .upd_ret(upd_ret),
      .upd_is_branch(upd_is_branch), .upd_is_j(upd_is_j), .upd_is_jal(upd_is_jal),
      .upd_is_jalr(upd_is_jalr), .upd_is_jr_ra(upd_is_jr_ra), .upd_taken(upd_taken),
      .flush_ras(flush_ras), .stall(stall), .drop_cnt(drop_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs(input bit fl);
      upd_t e;
      bit   ev;
      ev = !m_flush && !fl && (sb.size() > 0);
      if (ev) e = sb[0];
      else    e = '{32'h0, 32'h0, 32'h0, 5'h0, 1'b0};
      chk("upd_valid", 32'(upd_valid), 32'(ev));
      chk("upd_pc", upd_pc, e.pc);
      chk("upd_dest", upd_dest, e.dest);
      chk("upd_ret", upd_ret, e.ret);
      chk("upd_kind", 32'({upd_is_jr_ra, upd_is_jalr, upd_is_jal, upd_is_j, upd_is_branch}), 32'(e.kind));
      chk("upd_taken", 32'(upd_taken), 32'(e.taken));
      chk("flush_ras", 32'(flush_ras), 32'(m_flush));
      chk("stall", 32'(stall), 32'((DEPTH - sb.size()) < 2));
      chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
   endtask

   task automatic cycle(input bit v0, input logic [4:0] k0, input logic [31:0] pc0, input logic [31:0] d0,
                        input bit t0, input bit v1, input logic [4:0] k1, input logic [31:0] pc1,
                        input logic [31:0] d1, input bit t1, input bit fl);
      int drops;
      req0_valid = v0; req0_kind = k0; req0_pc = pc0; req0_dest = d0; req0_ret = pc0 + 32'd4; req0_taken = t0;
      req1_valid = v1; req1_kind = k1; req1_pc = pc1; req1_dest = d1; req1_ret = pc1 + 32'd4; req1_taken = t1;
      flush_in   = fl;
      @(negedge clk);
      check_outputs(fl);
      drops = 0;
      if (fl) begin
         sb.delete();
      end else begin
         if (!m_flush && sb.size() > 0) void'(sb.pop_front());
         if (v0 && k0 != 5'd0) begin
            if (sb.size() < DEPTH) sb.push_back('{pc0, d0, pc0 + 32'd4, k0, t0});
            else drops++;
         end
         if (v1 && k1 != 5'd0) begin
            if (sb.size() < DEPTH) sb.push_back('{pc1, d1, pc1 + 32'd4, k1, t1});
            else drops++;
         end
         m_drop = (m_drop + drops > SAT) ? SAT : m_drop + drops;
      end
      m_flush = fl;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input bit fl);
      cycle(1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, fl);
   endtask

   task automatic dual(input bit fl);
      logic [31:0] p;
      p = 32'h8000_1000 + 32'(seq) * 32'd8;
      cycle(1'b1, 5'(1 << (seq % 5)), p, p ^ 32'h0000_F000, seq[0],
            1'b1, 5'(1 << ((seq + 2) % 5)), p + 32'd4, p ^ 32'h00F0_0000, ~seq[0], fl);
      seq++;
   endtask

   task automatic rnd_cycle();
      int          r0, r1;
      logic [31:0] p;
      r0 = $urandom_range(0, 5);
      r1 = $urandom_range(0, 5);
      p  = 32'h9000_0000 + 32'(seq) * 32'd8;
      cycle(1'($urandom_range(0, 1)), (r0 == 5) ? 5'd0 : 5'(1 << r0), p, $urandom, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), (r1 == 5) ? 5'd0 : 5'(1 << r1), p + 32'd4, $urandom, 1'($urandom_range(0, 1)),
            $urandom_range(0, 9) == 0);
      seq++;
   endtask

   initial begin
      reset = 1'b1;
      req0_valid = 1'b0; req0_kind = '0; req0_pc = '0; req0_dest = '0; req0_ret = '0; req0_taken = 1'b0;
      req1_valid = 1'b0; req1_kind = '0; req1_pc = '0; req1_dest = '0; req1_ret = '0; req1_taken = 1'b0;
      flush_in = 1'b0;
      #1;
      check_outputs(1'b0);
      @(posedge clk);
      #1;
      reset = 1'b0;

      // single branch into an empty queue, then an illegal zero-kind request that must be ignored
      cycle(1'b1, 5'b00001, 32'h8000_0100, 32'h8000_0200, 1'b1, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0);
      idle(1'b0);
      cycle(1'b1, 5'd0, 32'h8000_0300, 32'h8000_0400, 1'b1, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0);
      idle(1'b0);
      idle(1'b0);

      // dual stream honouring stall: no drops
      for (int i = 0; i < 10; i++) begin
         if ((DEPTH - sb.size()) < 2) idle(1'b0);
         else dual(1'b0);
      end
      for (int i = 0; i < 5; i++) idle(1'b0);

      // dual stream ignoring stall for 6 cycles
      for (int i = 0; i < 6; i++) dual(1'b0);
      for (int i = 0; i < 5; i++) idle(1'b0);

      // flush with 3 entries queued
      dual(1'b0);
      dual(1'b0);
      dual(1'b1);
      idle(1'b0);
      idle(1'b0);

      // back-to-back flush, requests in the second flush cycle discarded
      dual(1'b0);
      dual(1'b0);
      dual(1'b1);
      dual(1'b1);
      dual(1'b0);
      for (int i = 0; i < 5; i++) idle(1'b0);

      for (int i = 0; i < 80; i++) rnd_cycle();
      for (int i = 0; i < 5; i++) idle(1'b0);

      // drop counter saturation
      for (int i = 0; i < 270; i++) dual(1'b0);
      for (int i = 0; i < 5; i++) idle(1'b0);

      // asynchronous reset with a full queue, between clock edges
      dual(1'b0);
      dual(1'b0);
      dual(1'b0);
      reset = 1'b1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      #2;
      sb.delete();
      m_drop  = 0;
      m_flush = 1'b0;
      check_outputs(1'b0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      dual(1'b0);
      idle(1'b0);
      idle(1'b0);
      idle(1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
